// File: rtl/bomberman_collision.sv
// Collision scanner for the bomberman sprite: snapshots the position, probes the
// tile map around the 16x16 sprite and commits a 4-bit blocked vector every 11 cycles.
module bomberman_collision #(
    parameter int ARENA_X0 = 144,
    parameter int ARENA_Y0 = 144,
    parameter int TILE     = 16,
    parameter int COLS     = 37,
    parameter int ROWS     = 22,
    parameter int AW       = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [9:0]    b_x,
    input  logic [9:0]    b_y,
    output logic          map_rd_en,
    output logic [AW-1:0] map_addr,
    input  logic [1:0]    map_data,
    output logic [3:0]    bomberman_blocked,
    output logic          scan_done
);

    localparam int SH     = $clog2(TILE);
    localparam int AREA_W = COLS * TILE;
    localparam int AREA_H = ROWS * TILE;

    typedef enum logic [1:0] {SNAP, PROBE, DRAIN, COMMIT} state_t;

    state_t      state_r;
    logic [2:0]  idx_r;
    logic [10:0] rx_r, ry_r;
    logic        oob_r;
    logic [3:0]  scratch_r;
    logic        rd_d_r;
    logic [1:0]  dir_d_r;

    logic [10:0]   rx_s, ry_s, nrx_s, nry_s;
    logic          oob_s, noob_s, issue_s, nforced_s, nrd_s, cap_s, frc_s;
    logic [2:0]    nidx_s;
    logic [AW-1:0] naddr_s;
    logic [3:0]    base_s, scratch_nx_s;

    // Probe index: bits [2:1] pick the direction, bit 0 picks the second row/column.
    function automatic logic [AW-1:0] probe_addr(input logic [2:0] idx,
                                                 input logic [10:0] rx,
                                                 input logic [10:0] ry);
        logic [10:0] col;
        logic [10:0] row;
        logic [10:0] lin;
        case (idx[2:1])
            2'd0:    col = (rx - 11'd1) >> SH;
            2'd1:    col = (rx + 11'd16) >> SH;
            default: col = idx[0] ? ((rx + 11'd15) >> SH) : (rx >> SH);
        endcase
        case (idx[2:1])
            2'd2:    row = (ry - 11'd1) >> SH;
            2'd3:    row = (ry + 11'd16) >> SH;
            default: row = idx[0] ? ((ry + 11'd15) >> SH) : (ry >> SH);
        endcase
        lin = row * 11'(COLS) + col;
        return lin[AW-1:0];
    endfunction

    // A probe whose target pixel falls outside the arena never reads the map.
    function automatic logic probe_forced(input logic [2:0] idx,
                                          input logic [10:0] rx,
                                          input logic [10:0] ry);
        logic f;
        case (idx[2:1])
            2'd0:    f = (rx == 11'd0);
            2'd1:    f = ((rx + 11'd16) == 11'(AREA_W));
            2'd2:    f = (ry == 11'd0);
            default: f = ((ry + 11'd16) == 11'(AREA_H));
        endcase
        return f;
    endfunction

    // Geometry of the live position and selection of the next probe to issue.
    always_comb begin
        rx_s  = {1'b0, b_x} - 11'(ARENA_X0);
        ry_s  = {1'b0, b_y} - 11'(ARENA_Y0);
        oob_s = (b_x < 10'(ARENA_X0)) || (b_y < 10'(ARENA_Y0)) ||
                ((rx_s + 11'd16) > 11'(AREA_W)) || ((ry_s + 11'd16) > 11'(AREA_H));
        if (state_r == SNAP) begin
            nidx_s  = 3'd0;
            nrx_s   = rx_s;
            nry_s   = ry_s;
            noob_s  = oob_s;
            issue_s = 1'b1;
        end else begin
            nidx_s  = idx_r + 3'd1;
            nrx_s   = rx_r;
            nry_s   = ry_r;
            noob_s  = oob_r;
            issue_s = (state_r == PROBE) && (idx_r != 3'd7);
        end
        naddr_s   = probe_addr(nidx_s, nrx_s, nry_s);
        nforced_s = probe_forced(nidx_s, nrx_s, nry_s);
        nrd_s     = issue_s && !noob_s && !nforced_s;
        frc_s     = issue_s && !noob_s && nforced_s;
        cap_s     = rd_d_r && (map_data != 2'd0);
        if (state_r == SNAP) begin
            base_s = oob_s ? 4'b1111 : 4'b0000;
        end else begin
            base_s = scratch_r;
        end
        scratch_nx_s = base_s | ({3'b000, cap_s} << dir_d_r) | ({3'b000, frc_s} << nidx_s[2:1]);
    end

    // Scan sequencer, read issue, result accumulation and atomic commit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r           <= SNAP;
            idx_r             <= 3'd0;
            rx_r              <= 11'd0;
            ry_r              <= 11'd0;
            oob_r             <= 1'b0;
            scratch_r         <= 4'b0000;
            rd_d_r            <= 1'b0;
            dir_d_r           <= 2'd0;
            map_rd_en         <= 1'b0;
            map_addr          <= {AW{1'b0}};
            bomberman_blocked <= 4'b1111;
            scan_done         <= 1'b0;
        end else begin
            scan_done <= 1'b0;
            map_rd_en <= nrd_s;
            map_addr  <= nrd_s ? naddr_s : {AW{1'b0}};
            scratch_r <= scratch_nx_s;
            rd_d_r    <= map_rd_en;
            dir_d_r   <= idx_r[2:1];
            case (state_r)
                SNAP: begin
                    rx_r    <= rx_s;
                    ry_r    <= ry_s;
                    oob_r   <= oob_s;
                    idx_r   <= 3'd0;
                    state_r <= PROBE;
                end
                PROBE: begin
                    if (idx_r == 3'd7) begin
                        state_r <= DRAIN;
                    end else begin
                        idx_r   <= idx_r + 3'd1;
                        state_r <= PROBE;
                    end
                end
                DRAIN: begin
                    state_r <= COMMIT;
                end
                COMMIT: begin
                    bomberman_blocked <= scratch_r;
                    scan_done         <= 1'b1;
                    state_r           <= SNAP;
                end
                default: begin
                    state_r <= SNAP;
                end
            endcase
        end
    end

endmodule
